uart_tx_engine: RTL and testbench

Self-contained, runtime-configurable UART transmitter. It replaces the fixed-format TX controller, serializer and parity path with a single block. It accepts a parallel word over a valid/ready handshake and generates a complete serial frame on o_tx: start, 5..MAX_DATA_WIDTH data bits LSB first, optional even/odd parity, then 1 or 2 stop bits. Bit timing comes from an internal prescale counter. It sits between the host-side TX register interface and the pad.

---
 rtl/uart_tx_engine.sv | 120 ++++++++++++
 tb/tb_uart_tx_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: runtime-configurable UART transmitter (start, 5..MAX data bits LSB first, optional parity, 1/2 stops).
module uart_tx_engine #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_W     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic [MAX_DATA_WIDTH-1:0] i_data,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  input  logic [3:0]                i_data_len,
  input  logic                      i_par_en,
  input  logic                      i_par_odd,
  input  logic                      i_stop2,
  input  logic [PRESCALE_W-1:0]     i_prescale,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_WIDTH);
  state_t                    state, state_n;
  logic [PRESCALE_W-1:0]     pcnt, pcnt_n, pre, pre_n;
  logic [3:0]                bcnt, bcnt_n, len, len_n;
  logic [MAX_DATA_WIDTH-1:0] sh, sh_n;
  logic                      par, par_n, par_en, par_en_n, stop2, stop2_n;
  logic                      tx_n, busy_n, done_n, last;
  assign o_data_ready = state == S_IDLE;
  assign last = pcnt == pre - 1'b1;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state  <= S_IDLE;
      pcnt   <= '0;
      pre    <= '0;
      bcnt   <= '0;
      len    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      par_en <= 1'b0;
      stop2  <= 1'b0;
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      pre    <= pre_n;
      bcnt   <= bcnt_n;
      len    <= len_n;
      sh     <= sh_n;
      par    <= par_n;
      par_en <= par_en_n;
      stop2  <= stop2_n;
      o_tx   <= tx_n;
      o_busy <= busy_n;
      o_done <= done_n;
    end
  end
  always_comb begin
    state_n  = state;
    pcnt_n   = (state == S_IDLE || last) ? '0 : pcnt + 1'b1;
    pre_n    = pre;
    bcnt_n   = bcnt;
    len_n    = len;
    sh_n     = sh;
    par_n    = par;
    par_en_n = par_en;
    stop2_n  = stop2;
    tx_n     = o_tx;
    busy_n   = o_busy;
    done_n   = 1'b0;
    case (state)
      S_IDLE: if (i_data_valid) begin
        state_n  = S_START;
        pre_n    = (i_prescale == '0) ? {{(PRESCALE_W-1){1'b0}}, 1'b1} : i_prescale;
        len_n    = (i_data_len < 4'd5) ? 4'd5 : (i_data_len > MAX_LEN ? MAX_LEN : i_data_len);
        sh_n     = i_data;
        par_n    = i_par_odd;
        par_en_n = i_par_en;
        stop2_n  = i_stop2;
        bcnt_n   = '0;
        tx_n     = 1'b0;
        busy_n   = 1'b1;
      end
      S_START: if (last) begin
        state_n = S_DATA;
        tx_n    = sh[0];
      end
      S_DATA: if (last) begin
        par_n = par ^ sh[0];
        sh_n  = sh >> 1;
        if (bcnt == len - 4'd1) begin
          bcnt_n  = '0;
          state_n = par_en ? S_PARITY : S_STOP;
          tx_n    = par_en ? par_n : 1'b1;
        end else begin
          bcnt_n = bcnt + 4'd1;
          tx_n   = sh_n[0];
        end
      end
      S_PARITY: if (last) begin
        state_n = S_STOP;
        tx_n    = 1'b1;
      end
      S_STOP: if (last) begin
        if (stop2 && bcnt == '0) bcnt_n = 4'd1;
        else begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized and directed frame checks against a bit-level frame model.
module tb_uart_tx_engine;
  localparam int MW = 9;
  localparam int PW = 16;
  logic          i_clk = 1'b0;
  logic          i_resetn = 1'b0;
  logic [MW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic [3:0]    i_data_len = 4'd8;
  logic          i_par_en = 1'b0;
  logic          i_par_odd = 1'b0;
  logic          i_stop2 = 1'b0;
  logic [PW-1:0] i_prescale = 16'd1;
  logic          o_data_ready, o_tx, o_busy, o_done;
  int   errors = 0;
  int   checks = 0;
  logic obs_q[$];
  int   nbusy, early_done;
  logic fin_done, fin_tx, fin_ready;

  uart_tx_engine #(.MAX_DATA_WIDTH(MW), .PRESCALE_W(PW)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_data_len(i_data_len), .i_par_en(i_par_en),
    .i_par_odd(i_par_odd), .i_stop2(i_stop2), .i_prescale(i_prescale),
    .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic int eff_len(int l);
    return l < 5 ? 5 : (l > MW ? MW : l);
  endfunction

  function automatic int frame_bits(int l, int pe, int s2);
    return 1 + eff_len(l) + pe + 1 + s2;
  endfunction

  // Expected line level for bit slot idx of a frame (0 = start bit).
  function automatic logic model_bit(int data, int l, int pe, int po, int idx);
    int n = eff_len(l);
    int ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= n) return ((data >> (idx - 1)) % 2) == 1;
    if (pe != 0 && idx == n + 1) begin
      for (int k = 0; k < n; k++) ones += (data >> k) % 2;
      return ((ones + po) % 2) == 1;
    end
    return 1'b1;
  endfunction

  function automatic int count_bad(int data, int l, int pe, int po, int p);
    int bad = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i] !== model_bit(data, l, pe, po, i / p)) bad++;
    return bad;
  endfunction

  task automatic start_frame(input int data, input int l, input int pe, input int po, input int s2, input int pres);
    int w = 0;
    while (o_data_ready !== 1'b1 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    i_data       = MW'(data);
    i_data_len   = 4'(l);
    i_par_en     = pe[0];
    i_par_odd    = po[0];
    i_stop2      = s2[0];
    i_prescale   = PW'(pres);
    i_data_valid = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic capture();
    obs_q.delete();
    nbusy = 0;
    early_done = 0;
    while (o_busy === 1'b1 && nbusy < 4000) begin
      obs_q.push_back(o_tx);
      nbusy++;
      if (o_done === 1'b1) early_done++;
      @(negedge i_clk);
    end
    fin_done  = o_done;
    fin_tx    = o_tx;
    fin_ready = o_data_ready;
  endtask

  task automatic test_frame(input string name, input int data, input int l, input int pe, input int po,
                            input int s2, input int pres, input int exp_len, input bit scramble);
    int p = pres == 0 ? 1 : pres;
    int bad;
    start_frame(data, l, pe, po, s2, pres);
    i_data_valid = 1'b0;
    if (scramble) begin
      i_data     = MW'($urandom);
      i_data_len = 4'($urandom);
      i_par_en   = 1'($urandom);
      i_par_odd  = 1'($urandom);
      i_stop2    = 1'($urandom);
      i_prescale = PW'($urandom_range(0, 7));
    end
    capture();
    bad = count_bad(data, l, pe, po, p);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s tx_bits: %0d wrong samples of %0d, required 0", name, bad, obs_q.size());
    end
    checks++;
    if (nbusy !== exp_len) begin
      errors++;
      $display("FAIL %s busy_len: got %0d required %0d", name, nbusy, exp_len);
    end
    checks++;
    if (fin_done !== 1'b1 || fin_ready !== 1'b1 || fin_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s end_cycle: done=%b ready=%b tx=%b required 1 1 1", name, fin_done, fin_ready, fin_tx);
    end
    checks++;
    if (early_done !== 0) begin
      errors++;
      $display("FAIL %s done_during_busy: got %0d required 0", name, early_done);
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: done=%b tx=%b required 0 1", name, o_done, o_tx);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o_tx !== 1'b1 || o_data_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b required 1 1 0 0", o_tx, o_data_ready, o_busy, o_done);
    end
    i_resetn = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_tx !== 1'b1 || o_data_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx=%b ready=%b busy=%b done=%b required 1 1 0 0", o_tx, o_data_ready, o_busy, o_done);
    end
  endtask

  task automatic test_vectors();
    test_frame("a5_p4_even", 'hA5, 8, 1, 0, 0, 4, 44, 1'b0);
    test_frame("41_p2_odd_stop2", 'h41, 7, 1, 1, 1, 2, 22, 1'b0);
    test_frame("1ff_p0_len9", 'h1FF, 9, 0, 0, 0, 0, 11, 1'b0);
    test_frame("len3_clamp", 'h3F, 3, 0, 0, 0, 3, 21, 1'b0);
    test_frame("len15_clamp", 'h155, 15, 1, 0, 1, 1, 13, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int d  = int'($urandom_range(0, 511));
      int l  = int'($urandom_range(0, 15));
      int pe = int'($urandom_range(0, 1));
      int po = int'($urandom_range(0, 1));
      int s2 = int'($urandom_range(0, 1));
      int pr = int'($urandom_range(0, 5));
      test_frame("random", d, l, pe, po, s2, pr, (pr == 0 ? 1 : pr) * frame_bits(l, pe, s2), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    start_frame('hC3, 8, 1, 0, 0, 4);
    i_data_valid = 1'b0;
    repeat (16) @(negedge i_clk);
    i_resetn = 1'b0;
    #1;
    checks++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: tx=%b busy=%b ready=%b required 1 0 1", o_tx, o_busy, o_data_ready);
    end
    @(negedge i_clk);
    checks++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_data_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_held: tx=%b busy=%b ready=%b done=%b required 1 0 1 0", o_tx, o_busy, o_data_ready, o_done);
    end
    i_resetn = 1'b1;
    test_frame("after_reset", 'h0B6, 8, 1, 1, 0, 3, 33, 1'b0);
  endtask

  task automatic test_back_to_back();
    int bad;
    int dones;
    start_frame('h55, 8, 0, 0, 0, 3);
    i_data     = MW'('hAA);
    i_stop2    = 1'b1;
    i_prescale = PW'(2);
    capture();
    dones = early_done + int'(fin_done === 1'b1);
    bad = count_bad('h55, 8, 0, 0, 3);
    checks++;
    if (bad !== 0 || nbusy !== 30) begin
      errors++;
      $display("FAIL b2b_frame1: bad=%0d busy=%0d required 0 30", bad, nbusy);
    end
    checks++;
    if (fin_tx !== 1'b1 || fin_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: tx=%b ready=%b required 1 1", fin_tx, fin_ready);
    end
    @(negedge i_clk);
    i_data_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frame2_start: busy=%b tx=%b required 1 0", o_busy, o_tx);
    end
    capture();
    dones += early_done + int'(fin_done === 1'b1);
    bad = count_bad('hAA, 8, 0, 0, 2);
    checks++;
    if (bad !== 0 || nbusy !== 22) begin
      errors++;
      $display("FAIL b2b_frame2: bad=%0d busy=%0d required 0 22", bad, nbusy);
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 2", dones);
    end
    @(negedge i_clk);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    test_reset();
    test_vectors();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
